// File: rtl/scan_chain_host.sv
// Purpose: host-side scan chain master; streams load bytes into the chain, returns displaced bits, or recirculates for readback.
// Latency: start -> first scan_enable in 2 cycles (load) / 1 cycle (rotate); 10 cycles/byte load, 9 cycles/byte rotate.
// Backpressure: in_valid low holds FETCH and out_ready low holds PUSH; the chain never shifts while waiting on either side.
module scan_chain_host #(
  parameter int CHAIN_LEN = 256,
  parameter int CNT_WIDTH = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rotate,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_WIDTH-1:0] NUM_BYTES = CNT_WIDTH'(CHAIN_LEN / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    PUSH  = 2'd3
  } state_t;

  state_t               state;
  logic                 rot_q;
  logic [7:0]           tx_sr;
  // Only seven bits are stored: the eighth captured bit goes straight into out_data.
  logic [6:0]           rx_sr;
  logic [2:0]           bit_cnt;
  logic [CNT_WIDTH-1:0] byte_cnt;

  // Rotate recirculates the tail bit into the head so a full pass leaves the chain intact.
  assign scan_in = rot_q ? scan_out : tx_sr[7];

  // Transfer sequencer; in_ready/scan_enable/out_valid are registered alongside the state they decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rot_q       <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      out_data    <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      scan_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort wins over everything; the chain is simply left where it stopped.
        state       <= IDLE;
        in_ready    <= 1'b0;
        out_valid   <= 1'b0;
        scan_enable <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              rot_q    <= rotate;
              byte_cnt <= '0;
              bit_cnt  <= '0;
              busy     <= 1'b1;
              if (rotate) begin
                state       <= SHIFT;
                scan_enable <= 1'b1;
              end else begin
                state    <= FETCH;
                in_ready <= 1'b1;
              end
            end
          end
          FETCH: begin
            if (in_valid && in_ready) begin
              tx_sr       <= in_data;
              bit_cnt     <= '0;
              state       <= SHIFT;
              in_ready    <= 1'b0;
              scan_enable <= 1'b1;
            end
          end
          SHIFT: begin
            rx_sr   <= {rx_sr[5:0], scan_out};
            tx_sr   <= {tx_sr[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              out_data    <= {rx_sr, scan_out};
              byte_cnt    <= byte_cnt + CNT_WIDTH'(1);
              state       <= PUSH;
              scan_enable <= 1'b0;
              out_valid   <= 1'b1;
            end
          end
          PUSH: begin
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              if (byte_cnt == NUM_BYTES) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (rot_q) begin
                state       <= SHIFT;
                scan_enable <= 1'b1;
              end else begin
                state    <= FETCH;
                in_ready <= 1'b1;
              end
            end
          end
          default: begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            scan_enable <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_host.sv
// Bench for scan_chain_host: behavioural CHAIN_LEN-bit chain around the DUT plus a bit-FIFO reference model.
// The model treats the chain as a queue ordered tail-first: every shift pops the tail bit and appends the new head bit.
// Loads/rotates use random data, random valid/ready stalls and stray start pulses; directed holds, abort and async reset are covered.
module tb_scan_chain_host;
  localparam int CHAIN_LEN = 256;
  localparam int NB        = CHAIN_LEN / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       rotate = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, scan_enable, scan_in, scan_out, busy, done;
  logic [7:0] out_data;

  int tests = 0;
  int fails = 0;

  // Physical chain: head at bit 0, tail at bit CHAIN_LEN-1.
  logic [CHAIN_LEN-1:0] chain = '0;
  int shift_cnt = 0;
  assign scan_out = chain[CHAIN_LEN-1];

  always @(posedge clk) begin
    if (scan_enable) begin
      chain     <= {chain[CHAIN_LEN-2:0], scan_in};
      shift_cnt <= shift_cnt + 1;
    end
  end

  initial forever #5 clk = ~clk;

  scan_chain_host #(.CHAIN_LEN(CHAIN_LEN), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .rotate(rotate), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
    .busy(busy), .done(done)
  );

  // Reference model: chain contents, index 0 = bit nearest the tail.
  bit         mq[$];
  logic [7:0] lb[NB];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [CHAIN_LEN-1:0] obs, input logic [CHAIN_LEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void apply_shifts(input int n, input bit rot);
    for (int i = 0; i < n; i++) begin
      bit b;
      b = mq.pop_front();
      mq.push_back(rot ? b : lb[i / 8][7 - (i % 8)]);
    end
  endfunction

  function automatic logic [CHAIN_LEN-1:0] model_vec();
    logic [CHAIN_LEN-1:0] v;
    for (int i = 0; i < CHAIN_LEN; i++) v[CHAIN_LEN-1-i] = mq[i];
    return v;
  endfunction

  task automatic randomize_lb();
    for (int k = 0; k < NB; k++) lb[k] = 8'($urandom_range(0, 255));
  endtask

  // One transfer; abort_at = shift index during which abort is raised (-1 none),
  // hold_fetch / hold_push = byte index at which the directed stall is applied (-1 none).
  task automatic run_xfer(input bit rot, input int stall_pct, input int abort_at,
                          input int hold_fetch, input int hold_push);
    logic [7:0] exp_b[NB];
    int base, n_in, n_out, ncyc, early_done, nbits, extra;
    bit fin;
    extra = ((hold_fetch >= 0 && !rot) ? 7 : 0) + ((hold_push >= 0) ? 5 : 0);
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < 8; j++) exp_b[k][7-j] = mq[8*k + j];
    base = shift_cnt; n_in = 0; n_out = 0; ncyc = 0; early_done = 0; fin = 0;
    nbits = (abort_at >= 0) ? abort_at + 1 : CHAIN_LEN;

    @(negedge clk);
    start = 1'b1; rotate = rot; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; rotate = 1'($urandom_range(0, 1));
    check("start_busy", busy, 1);
    if (rot) check("rot_first_shift", scan_enable, 1);
    else begin
      check("load_fetch_rdy", in_ready, 1);
      check("load_fetch_se", scan_enable, 0);
    end

    while (!fin && ncyc < 3000) begin
      if (abort_at >= 0 && scan_enable && (shift_cnt - base) == abort_at) begin
        abort = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check("abort_se", scan_enable, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bits", shift_cnt - base, abort_at + 1);
        fin = 1;
      end else if (n_in == hold_fetch && in_ready) begin
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        for (int c = 0; c < 7; c++) begin
          @(negedge clk); ncyc++;
          check("fetch_hold_rdy", in_ready, 1);
          check("fetch_hold_se", scan_enable, 0);
          check("fetch_hold_bits", shift_cnt - base, 8 * n_in);
        end
        hold_fetch = -1;
      end else if (n_out == hold_push && out_valid) begin
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk); ncyc++;
          check("push_hold_vld", out_valid, 1);
          check("push_hold_se", scan_enable, 0);
          check("push_hold_dat", out_data, exp_b[n_out]);
          check("push_hold_bits", shift_cnt - base, 8 * (n_out + 1));
        end
        hold_push = -1;
      end else begin
        in_valid  = (n_in < NB) && ($urandom_range(0, 99) >= stall_pct);
        in_data   = lb[n_in % NB];
        out_ready = ($urandom_range(0, 99) >= stall_pct);
        start     = ($urandom_range(0, 15) == 0);
        if (in_valid && in_ready) n_in++;
        if (out_valid && out_ready) begin
          check("out_byte", out_data, exp_b[n_out]);
          n_out++;
        end
        @(negedge clk); ncyc++;
        if (n_out == NB) begin
          check("done_pulse", done, 1);
          fin = 1;
        end else if (done) early_done++;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("xfer_finished", fin, 1);
    if (abort_at < 0) begin
      check("early_done", early_done, 0);
      if (stall_pct == 0) check("cycles", ncyc, (rot ? 288 : 320) + extra);
    end
    @(negedge clk);
    check("done_cleared", done, 0);
    check("idle_busy", busy, 0);
    check("idle_se", scan_enable, 0);
    check("shift_total", shift_cnt - base, nbits);
    apply_shifts(nbits, rot);
    check_w("chain_model", chain, model_vec());
  endtask

  initial begin
    int base;
    bit hit;
    for (int i = 0; i < CHAIN_LEN; i++) mq.push_back(1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_se", scan_enable, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b1;

    // Load 0x00..0x1F into a zero chain, then reload 0xFF to read them back
    for (int k = 0; k < NB; k++) lb[k] = 8'(k);
    run_xfer(1'b0, 0, -1, -1, -1);
    for (int k = 0; k < NB; k++) lb[k] = 8'hFF;
    run_xfer(1'b0, 0, -1, -1, -1);

    // Load a pattern, then two non-destructive rotate passes
    randomize_lb();
    lb[0] = 8'hA5; lb[1] = 8'h3C;
    run_xfer(1'b0, 0, -1, -1, -1);
    run_xfer(1'b1, 0, -1, -1, -1);
    run_xfer(1'b1, 25, -1, -1, -1);

    // Directed starvation in FETCH and backpressure in PUSH
    randomize_lb();
    run_xfer(1'b0, 0, -1, 4, 3);
    run_xfer(1'b1, 0, -1, -1, 6);

    // Abort during bit 3 of byte 5, then a normal readback
    randomize_lb();
    run_xfer(1'b0, 10, 5 * 8 + 3, -1, -1);
    @(negedge clk);
    start = 1'b1; abort = 1'b1; rotate = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_rdy", in_ready, 0);
    check("abort_start_se", scan_enable, 0);
    run_xfer(1'b1, 20, -1, -1, -1);

    // Async reset between clock edges while shifting
    randomize_lb();
    base = shift_cnt; hit = 0;
    @(negedge clk);
    start = 1'b1; rotate = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = lb[0];
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      in_data = lb[((shift_cnt - base) / 8) % NB];
      if (scan_enable && (shift_cnt - base) == 20) hit = 1;
    end
    check("rst_mid_reached", hit, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_se", scan_enable, 0);
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    check("arst_bits", shift_cnt - base, 20);
    apply_shifts(20, 1'b0);
    check_w("arst_chain", chain, model_vec());

    // Random traffic with heavy stalls
    randomize_lb();
    run_xfer(1'b0, 40, -1, -1, -1);
    run_xfer(1'b1, 40, -1, -1, -1);
    randomize_lb();
    run_xfer(1'b0, 50, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
